// File: rtl/prim_tribus_arb.sv
// N-channel shared tristate bus with a registered round-robin grant FSM and turnaround gaps.
// Optional bus keeper enabled by defining PRIM_TRIBUS_KEEPER_EN.
module prim_tribus_arb #(
    parameter int WIDTH      = 8,
    parameter int NCH        = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           req,
    input  logic [NCH*WIDTH-1:0]     din,
    output logic [NCH-1:0]           gnt,
    output logic [$clog2(NCH)-1:0]   owner,
    output logic                     bus_valid,
    output wire  [WIDTH-1:0]         bus_y
);

    localparam int OW = $clog2(NCH);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

    state_t        state;
    logic [OW-1:0] ptr;
    logic [HW-1:0] hold_cnt;
    logic [1:0]    turn_cnt;

    // Returns {found, index} of the first requester at or after start, wrapping.
    function automatic logic [OW:0] pick(input logic [NCH-1:0] r, input logic [OW-1:0] start);
        logic [OW:0] res;
        res = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            int idx;
            idx = (int'(start) + j) % NCH;
            if (r[idx]) res = {1'b1, OW'(idx)};
        end
        return res;
    endfunction

    logic [OW-1:0] ptr_nxt;
    logic [OW:0]   win_ptr;
    logic [OW:0]   win_rel;
    logic          others;
    logic          force_rel;
    logic          release_bus;

    assign ptr_nxt     = (owner == OW'(NCH - 1)) ? '0 : owner + OW'(1);
    assign win_ptr     = pick(req, ptr);
    assign win_rel     = pick(req, ptr_nxt);
    assign others      = |(req & ~gnt);
    assign force_rel   = (MAX_HOLD > 0) && others && (int'(hold_cnt) == MAX_HOLD - 1);
    assign release_bus = !req[owner] || force_rel;
    assign bus_valid   = |gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            turn_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_ptr[OW]) begin
                        state    <= DRIVE;
                        gnt      <= NCH'(1) << win_ptr[OW-1:0];
                        owner    <= win_ptr[OW-1:0];
                        hold_cnt <= '0;
                    end
                end
                DRIVE: begin
                    if (release_bus) begin
                        ptr      <= ptr_nxt;
                        hold_cnt <= '0;
                        if (TURNAROUND > 0) begin
                            state    <= TURN;
                            gnt      <= '0;
                            turn_cnt <= 2'(TURNAROUND - 1);
                        end else if (win_rel[OW]) begin
                            // Zero-turnaround handoff: old bit clears on the same edge the new one sets.
                            gnt   <= NCH'(1) << win_rel[OW-1:0];
                            owner <= win_rel[OW-1:0];
                        end else begin
                            state <= IDLE;
                            gnt   <= '0;
                        end
                    end else if ((MAX_HOLD > 0) && (int'(hold_cnt) < MAX_HOLD - 1)) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                TURN: begin
                    if (turn_cnt == 2'd0) begin
                        if (win_ptr[OW]) begin
                            state    <= DRIVE;
                            gnt      <= NCH'(1) << win_ptr[OW-1:0];
                            owner    <= win_ptr[OW-1:0];
                            hold_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        turn_cnt <= turn_cnt - 2'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            bufif1 u_drv (bus_y[b], din[i*WIDTH+b], gnt[i]);
        end
    end

`ifdef PRIM_TRIBUS_KEEPER_EN
    logic [WIDTH-1:0] keep_q;

    always_ff @(posedge clk) begin
        if (rst)            keep_q <= '0;
        else if (bus_valid) keep_q <= bus_y;
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_keep
        bufif0 u_keep (bus_y[b], keep_q[b], bus_valid);
    end
`endif

endmodule

// File: tb/tb_prim_tribus_arb.sv
// Bench for prim_tribus_arb: three configurations (TURNAROUND=1, TURNAROUND=0, MAX_HOLD=3)
// checked every cycle against a behavioural arbitration model, plus directed scenarios.
module tb_prim_tribus_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  rq [3];
    logic [31:0] din;

    logic [3:0] gnt0, gnt1, gnt2;
    logic [1:0] own0, own1, own2;
    logic       bv0, bv1, bv2;
    wire  [7:0] bus0, bus1, bus2;

    prim_tribus_arb #(.WIDTH(8), .NCH(4), .TURNAROUND(1), .MAX_HOLD(0)) dut_a (
        .clk(clk), .rst(rst), .req(rq[0]), .din(din),
        .gnt(gnt0), .owner(own0), .bus_valid(bv0), .bus_y(bus0));
    prim_tribus_arb #(.WIDTH(8), .NCH(4), .TURNAROUND(0), .MAX_HOLD(0)) dut_b (
        .clk(clk), .rst(rst), .req(rq[1]), .din(din),
        .gnt(gnt1), .owner(own1), .bus_valid(bv1), .bus_y(bus1));
    prim_tribus_arb #(.WIDTH(8), .NCH(4), .TURNAROUND(1), .MAX_HOLD(3)) dut_c (
        .clk(clk), .rst(rst), .req(rq[2]), .din(din),
        .gnt(gnt2), .owner(own2), .bus_valid(bv2), .bus_y(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: current owner (-1 = nobody), search start, cycles granted,
    // remaining idle gap, last owner, and remembered bus value.
    int         ta  [3] = '{1, 0, 1};
    int         mh  [3] = '{0, 0, 3};
    int         cur [3];
    int         ptr [3];
    int         held[3];
    int         gap [3];
    int         last[3];
    logic [7:0] keep[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic grab(input int k);
        for (int j = 0; j < 4; j++) begin
            int idx;
            idx = (ptr[k] + j) % 4;
            if (cur[k] < 0 && rq[k][idx]) begin
                cur[k]  = idx;
                last[k] = idx;
                held[k] = 1;
            end
        end
    endtask

    task automatic model_edge(input int k);
        if (rst) begin
            cur[k] = -1; ptr[k] = 0; held[k] = 0; gap[k] = 0; last[k] = 0; keep[k] = 8'h00;
        end else if (cur[k] >= 0) begin
            logic other;
            keep[k] = din[cur[k]*8 +: 8];
            other = (rq[k] & ~(4'b0001 << cur[k])) != 4'b0000;
            if (!rq[k][cur[k]] || (mh[k] > 0 && other && held[k] >= mh[k])) begin
                ptr[k] = (cur[k] + 1) % 4;
                cur[k] = -1;
                if (ta[k] > 0) gap[k] = ta[k];
                else grab(k);
            end else begin
                held[k]++;
            end
        end else if (gap[k] > 0) begin
            gap[k]--;
            if (gap[k] == 0) grab(k);
        end else begin
            grab(k);
        end
    endtask

    task automatic check_inst(input int k, input logic [3:0] g, input logic [1:0] o,
                              input logic v, input logic [7:0] y);
        logic [3:0] eg;
        eg = (cur[k] >= 0) ? (4'b0001 << cur[k]) : 4'b0000;
        chk($sformatf("gnt%0d", k), 32'(g), 32'(eg));
        chk($sformatf("owner%0d", k), 32'(o), 32'(last[k]));
        chk($sformatf("valid%0d", k), 32'(v), 32'(cur[k] >= 0));
        if (cur[k] >= 0) chk($sformatf("bus%0d", k), 32'(y), 32'(din[cur[k]*8 +: 8]));
`ifdef PRIM_TRIBUS_KEEPER_EN
        else chk($sformatf("keep%0d", k), 32'(y), 32'(keep[k]));
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_edge(k);
        #1;
        check_inst(0, gnt0, own0, bv0, bus0);
        check_inst(1, gnt1, own1, bv1, bus1);
        check_inst(2, gnt2, own2, bv2, bus2);
    endtask

    task automatic set_req(input logic [3:0] r);
        for (int k = 0; k < 3; k++) rq[k] = r;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    int order[$];
    int gaps[$];
    int idle_run;
    logic prev_bv;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        for (int k = 0; k < 3; k++) begin
            cur[k] = -1; ptr[k] = 0; held[k] = 0; gap[k] = 0; last[k] = 0; keep[k] = 8'h00;
        end
        din = $urandom();
        set_req(4'b1111);
        rst = 1'b1;

        // Reset held for two cycles with every channel requesting
        cycle();
        cycle();
        chk("rst_gnt", 32'(gnt0), 32'h0);
        chk("rst_valid", 32'(bv0), 32'h0);
        chk("rst_owner", 32'(own0), 32'h0);
`ifdef PRIM_TRIBUS_KEEPER_EN
        chk("rst_keep", 32'(bus0), 32'h00);
`endif
        rst = 1'b0;
        cycle();
        chk("first_gnt", 32'(gnt0), 32'h1);
        chk("first_bus", 32'(bus0), 32'(din[7:0]));

        // Round robin: each owner drops its request after two granted cycles
        do_reset();
        set_req(4'b1111);
        prev_bv  = 1'b0;
        idle_run = 0;
        for (int n = 0; n < 40 && order.size() < 5; n++) begin
            cycle();
            if (bv0 && !prev_bv) begin
                if (order.size() > 0) gaps.push_back(idle_run);
                order.push_back(int'(own0));
                idle_run = 0;
            end else if (!bv0) begin
                idle_run++;
            end
            prev_bv = bv0;
            for (int k = 0; k < 3; k++)
                rq[k] = (cur[k] >= 0 && held[k] >= 2) ? (4'b1111 & ~(4'b0001 << cur[k])) : 4'b1111;
        end
        chk("rr_count", 32'(order.size()), 32'd5);
        for (int i = 0; i < order.size() && i < 5; i++)
            chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
        for (int i = 0; i < gaps.size(); i++)
            chk($sformatf("rr_gap%0d", i), 32'(gaps[i]), 32'd1);

        // Zero-turnaround handoff 2 -> 3
        do_reset();
        set_req(4'b0100);
        cycle();
        chk("ta0_own2", 32'(gnt1), 32'h4);
        set_req(4'b1100);
        cycle();
        set_req(4'b1000);
        cycle();
        chk("ta0_gnt3", 32'(gnt1), 32'h8);
        chk("ta0_valid", 32'(bv1), 32'h1);

        // MAX_HOLD=3 forced release
        do_reset();
        set_req(4'b0001);
        cycle();
        chk("mh_g1", 32'(gnt2), 32'h1);
        set_req(4'b0011);
        cycle();
        chk("mh_g2", 32'(gnt2), 32'h1);
        cycle();
        chk("mh_g3", 32'(gnt2), 32'h1);
        cycle();
        chk("mh_turn", 32'(gnt2), 32'h0);
        cycle();
        chk("mh_next", 32'(gnt2), 32'h2);

`ifdef PRIM_TRIBUS_KEEPER_EN
        // Keeper retains last driven value after release
        do_reset();
        din = 32'h0000_A500;
        set_req(4'b0010);
        cycle();
        cycle();
        set_req(4'b0000);
        cycle();
        chk("keep_valid", 32'(bv0), 32'h0);
        chk("keep_a5", 32'(bus0), 32'hA5);
        cycle();
        chk("keep_idle", 32'(bus0), 32'hA5);
`endif

        // Reset pulse in the middle of a drive
        do_reset();
        set_req(4'b0010);
        cycle();
        chk("mid_gnt", 32'(gnt0), 32'h2);
        rst = 1'b1;
        set_req(4'b0011);
        cycle();
        chk("mid_rst", 32'(gnt0), 32'h0);
        rst = 1'b0;
        cycle();
        chk("mid_after", 32'(gnt0), 32'h1);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            din = $urandom();
            for (int k = 0; k < 3; k++) rq[k] = 4'($urandom());
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
